// File: rtl/instr_trace_pkg.sv
// Shared constants for the instrumentation trace poller: adapter word map,
// snapshot field layout and FSM state encoding.
package instr_trace_pkg;

  localparam logic [1:0] ADDR_INSTR = 2'd0;
  localparam logic [1:0] ADDR_PC    = 2'd1;
  localparam logic [1:0] ADDR_STATE = 2'd2;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 10;
  localparam int unsigned STATE_W = 5;
  localparam int unsigned SNAP_W  = 32;

  localparam int unsigned SNAP_INSTR_LSB = 0;
  localparam int unsigned SNAP_PC_LSB    = SNAP_INSTR_LSB + INSTR_W;
  localparam int unsigned SNAP_STATE_LSB = SNAP_PC_LSB + PC_W;
  localparam int unsigned SNAP_LOST_BIT  = SNAP_STATE_LSB + STATE_W;

  typedef logic [2:0] fsm_state_t;

  localparam fsm_state_t IDLE = 3'd0;
  localparam fsm_state_t A0   = 3'd1;
  localparam fsm_state_t A1   = 3'd2;
  localparam fsm_state_t A2   = 3'd3;
  localparam fsm_state_t CAP  = 3'd4;
  localparam fsm_state_t PUSH = 3'd5;

  function automatic logic [SNAP_W-1:0] pack_snapshot(input logic               lost,
                                                      input logic [STATE_W-1:0] core_state,
                                                      input logic [PC_W-1:0]    pc,
                                                      input logic [INSTR_W-1:0] instr);
    return {lost, core_state, pc, instr};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through snapshot FIFO; pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate count.
module trace_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_trace_poller.sv
// Periodically reads the instr/pc/state words of the instrumentation adapter and
// streams packed 32-bit snapshots to the host debug link through a small FIFO.
module instr_trace_poller
  import instr_trace_pkg::*;
#(
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DROP_W     = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                trigger,
  output logic [1:0]          avm_address,
  output logic                avm_read,
  input  logic [15:0]         avm_readdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SNAP_W-1:0]   out_data,
  output logic                busy,
  output logic [DROP_W-1:0]   drop_count
);

  localparam logic [PERIOD_W-1:0] PeriodOne = 1;
  localparam logic [DROP_W-1:0]   DropOne   = 1;

  fsm_state_t          state_q, state_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic                timer_run_q, timer_run_d;
  logic                pending_q, pending_d;
  logic                lost_q, lost_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [INSTR_W-1:0]  instr_q;
  logic [PC_W-1:0]     pc_q;
  logic [STATE_W-1:0]  core_state_q;
  logic                tick, timer_active;
  logic                push, pop, accepted, dropped;
  logic                fifo_full, fifo_empty;

  assign timer_active = enable && (period != '0);

  always_comb begin
    tick        = 1'b0;
    timer_d     = timer_q;
    timer_run_d = timer_run_q;
    if (!timer_active) begin
      timer_d     = '0;
      timer_run_d = 1'b0;
    end else if (!timer_run_q) begin
      timer_d     = period - PeriodOne;
      timer_run_d = 1'b1;
    end else if (timer_q == '0) begin
      tick    = 1'b1;
      timer_d = period - PeriodOne;
    end else begin
      timer_d = timer_q - PeriodOne;
    end
  end

  // Requests arriving while one is already pending collapse into it.
  assign pending_d = (pending_q && (state_q != IDLE)) || tick || trigger;

  always_comb begin
    state_d     = state_q;
    avm_address = ADDR_INSTR;
    avm_read    = 1'b0;
    case (state_q)
      IDLE: if (pending_q) state_d = A0;
      A0: begin
        avm_read = 1'b1;
        state_d  = A1;
      end
      A1: begin
        avm_address = ADDR_PC;
        avm_read    = 1'b1;
        state_d     = A2;
      end
      A2: begin
        avm_address = ADDR_STATE;
        avm_read    = 1'b1;
        state_d     = CAP;
      end
      CAP: begin
        avm_address = ADDR_STATE;
        state_d     = PUSH;
      end
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign push     = (state_q == PUSH);
  assign pop      = out_valid && out_ready;
  assign accepted = push && (!fifo_full || pop);
  assign dropped  = push && fifo_full && !pop;

  always_comb begin
    lost_d = lost_q;
    drop_d = drop_q;
    if (dropped) begin
      lost_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DropOne;
    end else if (accepted) begin
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      timer_run_q  <= 1'b0;
      pending_q    <= 1'b0;
      lost_q       <= 1'b0;
      drop_q       <= '0;
      instr_q      <= '0;
      pc_q         <= '0;
      core_state_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      timer_run_q <= timer_run_d;
      pending_q   <= pending_d;
      lost_q      <= lost_d;
      drop_q      <= drop_d;
      // Each word arrives one cycle after its address was driven.
      if (state_q == A1)  instr_q      <= avm_readdata;
      if (state_q == A2)  pc_q         <= avm_readdata[PC_W-1:0];
      if (state_q == CAP) core_state_q <= avm_readdata[STATE_W-1:0];
    end
  end

  assign drop_count = drop_q;
  assign out_valid  = !fifo_empty;

  trace_fifo #(
    .WIDTH (SNAP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accepted),
    .wdata   (pack_snapshot(lost_q, core_state_q, pc_q, instr_q)),
    .pop     (pop),
    .rdata   (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_instr_trace_poller.sv
// Scoreboard bench for instr_trace_poller: stimulus pushes expected snapshots,
// a negedge monitor pops and compares whenever the DUT hands one over.
module tb_instr_trace_poller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] period;
  logic        trigger;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [15:0] avm_readdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic [7:0]  drop_count;

  instr_trace_poller dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .period       (period),
    .trigger      (trigger),
    .avm_address  (avm_address),
    .avm_read     (avm_read),
    .avm_readdata (avm_readdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  // {lost, state=5'h13, pc=10'h2A5} occupies the upper half.
  localparam logic [31:0] SnapHi     = 32'h4EA5_0000;
  localparam logic [31:0] SnapHiLost = 32'hCEA5_0000;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [31:0] exp_q [$];
  int          pop_t [$];
  logic        free_run = 1'b0;
  logic [15:0] instr_v  = 16'hBEEF;
  logic [9:0]  pc_v     = 10'h2A5;
  logic [4:0]  st_v     = 5'h13;

  // Adapter model: one-cycle read latency, garbage in the unused upper bits.
  always @(posedge clk) begin
    if (!avm_read) avm_readdata <= 16'hDEAD;
    else begin
      case (avm_address)
        2'd0:    avm_readdata <= instr_v;
        2'd1:    avm_readdata <= {6'b101101, pc_v};
        2'd2:    avm_readdata <= {11'h5A5, st_v};
        default: avm_readdata <= 16'hDEAD;
      endcase
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      pop_t.push_back(cyc);
      if (free_run) check("free_run_data", out_data, 32'h4EA5_BEEF);
      else if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_pop: got %h, expected no entry", out_data);
      end else check("sb_data", out_data, exp_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
  endtask

  logic [4:0] seq_exp [6];
  int         n0;

  initial begin
    reset_n   = 1'b1;
    enable    = 1'b0;
    period    = '0;
    trigger   = 1'b0;
    out_ready = 1'b0;
    #2 reset_n = 1'b0;
    step(3);
    check("reset_ctrl", {27'd0, out_valid, busy, avm_read, avm_address}, 32'd0);
    check("reset_data", out_data, 32'd0);
    check("reset_drop", {24'd0, drop_count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(2);

    // Single trigger: address walk and snapshot layout.
    seq_exp[0] = 5'b0_1_1_00;
    seq_exp[1] = 5'b0_1_1_01;
    seq_exp[2] = 5'b0_1_1_10;
    seq_exp[3] = 5'b0_1_0_10;
    seq_exp[4] = 5'b0_1_0_00;
    seq_exp[5] = 5'b1_0_0_00;
    exp_q.push_back(32'h4EA5_BEEF);
    pulse_trigger();
    for (int i = 0; i < 6; i++) begin
      step(1);
      check($sformatf("seq_%0d", i), {27'd0, out_valid, busy, avm_read, avm_address},
            {27'd0, seq_exp[i]});
    end
    check("t1_head", out_data, 32'h4EA5_BEEF);
    out_ready = 1'b1;
    step(3);
    check("t1_drained", {31'd0, out_valid}, 32'd0);

    // Periodic sampling, period 20.
    pop_t.delete();
    free_run = 1'b1;
    period   = 16'd20;
    enable   = 1'b1;
    for (int i = 0; i < 100 && pop_t.size() == 0; i++) step(1);
    check("t2_first_pop", {31'd0, pop_t.size() > 0}, 32'd1);
    step(210);
    enable = 1'b0;
    step(20);
    n0 = 0;
    foreach (pop_t[i]) if (pop_t[i] - pop_t[0] < 200) n0++;
    check("t2_count", n0, 10);
    for (int i = 1; i < 10 && i < pop_t.size(); i++)
      check($sformatf("t2_gap_%0d", i), pop_t[i] - pop_t[i-1], 20);
    check("t2_drop", {24'd0, drop_count}, 32'd0);

    // Period 3: requests coalesce, snapshots back to back.
    pop_t.delete();
    period = 16'd3;
    enable = 1'b1;
    for (int i = 0; i < 100 && pop_t.size() < 6; i++) step(1);
    enable = 1'b0;
    check("t4_pops", {31'd0, pop_t.size() >= 6}, 32'd1);
    for (int i = 1; i < 6 && i < pop_t.size(); i++)
      check($sformatf("t4_gap_%0d", i), pop_t[i] - pop_t[i-1], 6);
    step(20);
    check("t4_drop", {24'd0, drop_count}, 32'd0);
    free_run = 1'b0;

    // Overflow: ten triggers into a stalled FIFO.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      instr_v = 16'h1000 + 16'(i);
      if (i < 8) exp_q.push_back(SnapHi | (32'h1000 + i));
      pulse_trigger();
      step(7);
    end
    check("t3_drop", {24'd0, drop_count}, 32'd2);
    check("t3_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step(10);
    check("t3_drained", {31'd0, out_valid}, 32'd0);
    instr_v = 16'h2000;
    exp_q.push_back(SnapHiLost | 32'h2000);
    pulse_trigger();
    step(7);
    instr_v = 16'h2001;
    exp_q.push_back(SnapHi | 32'h2001);
    pulse_trigger();
    step(7);
    check("t3_sb_empty", exp_q.size(), 0);

    // Full FIFO with a pop coinciding with PUSH.
    out_ready = 1'b0;
    pop_t.delete();
    for (int i = 0; i < 9; i++) begin
      instr_v = 16'h3000 + 16'(i);
      exp_q.push_back(SnapHi | (32'h3000 + i));
      if (i < 8) begin
        pulse_trigger();
        step(7);
      end
    end
    pulse_trigger();
    step(5);
    check("t5_in_push", {29'd0, busy, avm_read, out_valid}, 32'b101);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("t5_still_full", {31'd0, out_valid}, 32'd1);
    check("t5_drop", {24'd0, drop_count}, 32'd2);
    out_ready = 1'b1;
    step(12);
    check("t5_pops", pop_t.size(), 9);
    check("t5_sb_empty", exp_q.size(), 0);

    // Reset while the master is in A2.
    out_ready = 1'b0;
    instr_v   = 16'h4000;
    pulse_trigger();
    step(7);
    check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    pulse_trigger();
    step(3);
    check("t6_in_a2", {29'd0, avm_read, avm_address}, 32'b110);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_ctrl", {27'd0, out_valid, busy, avm_read, avm_address}, 32'd0);
    check("t6_rst_data", out_data, 32'd0);
    check("t6_rst_drop", {24'd0, drop_count}, 32'd0);
    exp_q.delete();
    step(2);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    pop_t.delete();
    step(15);
    check("t6_no_stale", {30'd0, out_valid, busy}, 32'd0);
    check("t6_no_pops", pop_t.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
